// File: rtl/core8_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 15-atom packets for the OCI trace sink; optional drop counter via CORE8_DCT_DROP_COUNT_EN.
// Latency: packet presented 1 cycle after the transfer condition (full, pending flush, or draining).
// Backpressure: out_valid/out_ready holds the packet; atoms arriving to a full, blocked accumulator are dropped and flagged.
module core8_cpu_oci_dct_packer #(
    parameter int ATOM_W    = 2,
    parameter int MAX_ATOMS = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          atom_valid,
    input  logic [ATOM_W-1:0]             atom_data,
    input  logic                          flush,
    input  logic                          test_end_req,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [ATOM_W*MAX_ATOMS-1:0]   dct_buffer,
    output logic [3:0]                    dct_count,
    output logic                          drop_flag,
    output logic                          test_ending,
`ifdef CORE8_DCT_DROP_COUNT_EN
    output logic [15:0]                   drop_count,
`endif
    output logic                          test_has_ended
);

    localparam int BUF_W = ATOM_W * MAX_ATOMS;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t             state;
    logic [BUF_W-1:0]   acc;
    logic [3:0]         acc_cnt;
    logic               flush_pending;

    logic               slot_free;
    logic               acc_full;
    logic               xfer;
    logic               atom_take;
    logic               atom_drop;
    logic [BUF_W-1:0]   base_acc;
    logic [3:0]         base_cnt;
    logic [BUF_W-1:0]   acc_nx;
    logic [3:0]         cnt_nx;
    logic               flush_nx;
    logic               drain_done;
`ifdef CORE8_DCT_DROP_COUNT_EN
    logic [15:0]        drop_count_nx;
`endif

    always_comb begin
        slot_free  = !out_valid || out_ready;
        acc_full   = (acc_cnt == 4'(MAX_ATOMS));
        xfer       = slot_free &&
                     (acc_full || ((flush_pending || state == ST_DRAIN) && acc_cnt != 4'd0));
        atom_take  = atom_valid && (state != ST_ENDED);
        atom_drop  = atom_take && acc_full && !xfer;
        drain_done = (acc_cnt == 4'd0) && !atom_valid && !out_valid;

        // A transfer empties the accumulator first, so a same-cycle atom lands in slot 0.
        base_acc = xfer ? '0 : acc;
        base_cnt = xfer ? 4'd0 : acc_cnt;
        acc_nx   = base_acc;
        cnt_nx   = base_cnt;
        if (atom_take && !atom_drop) begin
            for (int i = 0; i < MAX_ATOMS; i++) begin
                if (base_cnt == 4'(i)) begin
                    acc_nx[i*ATOM_W +: ATOM_W] = atom_data;
                end
            end
            cnt_nx = 4'(base_cnt + 4'd1);
        end

        // Pending flush survives only while something is left to send.
        flush_nx = (flush_pending || (flush && state != ST_ENDED)) && !xfer && (cnt_nx != 4'd0);

`ifdef CORE8_DCT_DROP_COUNT_EN
        drop_count_nx = drop_count;
        if (atom_drop && drop_count != 16'hFFFF) begin
            drop_count_nx = drop_count + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            acc            <= '0;
            acc_cnt        <= 4'd0;
            flush_pending  <= 1'b0;
            out_valid      <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= 4'd0;
            drop_flag      <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
`ifdef CORE8_DCT_DROP_COUNT_EN
            drop_count     <= 16'd0;
`endif
        end else begin
            acc           <= acc_nx;
            acc_cnt       <= cnt_nx;
            flush_pending <= flush_nx;

            if (xfer) begin
                dct_buffer <= acc;
                dct_count  <= acc_cnt;
                out_valid  <= 1'b1;
            end else if (slot_free) begin
                out_valid  <= 1'b0;
            end

`ifdef CORE8_DCT_DROP_COUNT_EN
            drop_count <= drop_count_nx;
            drop_flag  <= (drop_count_nx != 16'd0);
`else
            drop_flag  <= drop_flag || atom_drop;
`endif

            case (state)
                ST_RUN: begin
                    if (test_end_req) begin
                        state       <= ST_DRAIN;
                        test_ending <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state          <= ST_ENDED;
                        test_ending    <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    state <= ST_ENDED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core8_cpu_oci_dct_packer.sv
// Bench for core8_cpu_oci_dct_packer: directed scenarios plus random traffic against a queue-based packet model.
module tb_core8_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        flush = 1'b0;
    logic        test_end_req = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        drop_flag;
    logic        test_ending;
    logic        test_has_ended;
`ifdef CORE8_DCT_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    core8_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .flush          (flush),
        .test_end_req   (test_end_req),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .drop_flag      (drop_flag),
        .test_ending    (test_ending),
`ifdef CORE8_DCT_DROP_COUNT_EN
        .drop_count     (drop_count),
`endif
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending atoms as a queue, phase as RUN(0)/DRAIN(1)/ENDED(2).
    int          m_q[$];
    bit          m_fp;
    int          m_st;
    bit          m_ov;
    logic [29:0] m_buf;
    int          m_cnt;
    bit          m_drop;
    int          m_dcnt;
    bit          m_te;
    bit          m_the;

    function automatic logic [29:0] pack_q();
        logic [29:0] r = '0;
        foreach (m_q[i]) r = r | (30'(m_q[i] & 3) << (2 * i));
        return r;
    endfunction

    task automatic model_step();
        bit slot, full, x, take, drop, exit_drain;
        if (reset) begin
            m_q.delete();
            m_fp = 0; m_st = 0; m_ov = 0; m_buf = '0; m_cnt = 0;
            m_drop = 0; m_dcnt = 0; m_te = 0; m_the = 0;
            return;
        end
        slot       = !m_ov || out_ready;
        full       = (m_q.size() == 15);
        x          = slot && (full || ((m_fp || m_st == 1) && m_q.size() != 0));
        take       = atom_valid && m_st != 2;
        drop       = take && full && !x;
        exit_drain = (m_st == 1) && m_q.size() == 0 && !atom_valid && !m_ov;
        if (x) begin
            m_buf = pack_q();
            m_cnt = m_q.size();
            m_ov  = 1;
            m_q.delete();
        end else if (slot) begin
            m_ov = 0;
        end
        if (take && !drop) m_q.push_back(int'(atom_data));
        m_fp = (m_fp || (flush && m_st != 2)) && !x && m_q.size() != 0;
        if (drop) begin
            m_drop = 1;
            if (m_dcnt < 65535) m_dcnt++;
        end
        if (m_st == 0 && test_end_req) begin
            m_st = 1; m_te = 1;
        end else if (exit_drain) begin
            m_st = 2; m_te = 0; m_the = 1;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, m_ov);
        chk("dct_count", dct_count, m_cnt);
        chk("dct_buffer", dct_buffer, m_buf);
        chk("drop_flag", drop_flag, m_drop);
        chk("test_ending", test_ending, m_te);
        chk("test_has_ended", test_has_ended, m_the);
`ifdef CORE8_DCT_DROP_COUNT_EN
        chk("drop_count", drop_count, m_dcnt);
`endif
    endtask

    task automatic step(input logic av, input logic [1:0] ad, input logic fl,
                        input logic ter, input logic rdy, input logic rst);
        atom_valid   = av;
        atom_data    = ad;
        flush        = fl;
        test_end_req = ter;
        out_ready    = rdy;
        reset        = rst;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic wait_pkt(input string tag, input int exp_cnt, input logic [29:0] exp_buf);
        for (int i = 0; i < 20 && !out_valid; i++) step(0, 0, 0, 0, 1, 0);
        chk({tag, "_seen"}, out_valid, 1);
        chk({tag, "_cnt"}, dct_count, exp_cnt);
        chk({tag, "_buf"}, dct_buffer, exp_buf);
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dct_buffer", dct_buffer, 0);
        chk("rst_dct_count", dct_count, 0);
        chk("rst_drop_flag", drop_flag, 0);
        chk("rst_test_ending", test_ending, 0);
        chk("rst_test_has_ended", test_has_ended, 0);

        // Full packet of 0,1,2,3,... from the LSB.
        for (int i = 0; i < 15; i++) step(1, 2'(i % 4), 0, 0, 1, 0);
        wait_pkt("full15", 15, 30'h24E4E4E4);
        step(0, 0, 0, 0, 1, 0);
        chk("full15_one_cycle", out_valid, 0);

        // Partial packet via flush, then an empty flush.
        step(1, 2'd3, 0, 0, 1, 0);
        step(1, 2'd2, 0, 0, 1, 0);
        step(1, 2'd1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        wait_pkt("flush3", 3, 30'h0000001B);
        step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("empty_flush_nopkt", out_valid, 0);
        end

        // Blocked consumer: hold first packet, fill accumulator, drop the 31st atom.
        do_reset();
        for (int i = 0; i < 30; i++) step(1, 2'($urandom_range(0, 3)), 0, 0, 0, 0);
        chk("bp_no_drop_yet", drop_flag, 0);
        step(1, 2'd1, 0, 0, 0, 0);
        chk("bp_drop_flag", drop_flag, 1);
`ifdef CORE8_DCT_DROP_COUNT_EN
        chk("bp_drop_count", drop_count, 1);
`endif
        step(0, 0, 0, 0, 1, 0);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_cnt", dct_count, 15);

        // 16th atom opens the next packet; flush sends it alone.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 2'(i % 4), 0, 0, 1, 0);
        chk("a16_pkt_cnt", dct_count, 15);
        step(0, 0, 1, 0, 1, 0);
        wait_pkt("a16_flush", 1, 30'h3);

        // Reset with a held packet and a partial accumulator.
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 2'd2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 2'd1, 0, 0, 0, 0);
        chk("mid_pre_valid", out_valid, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_buf", dct_buffer, 0);
        chk("mid_rst_cnt", dct_count, 0);
        step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("mid_flush_nopkt", out_valid, 0);
        end

        // End-of-test drain.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'(3 - (i % 4)), 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("drain_ending", test_ending, 1);
        wait_pkt("drain5", 5, 30'h0000031B);
        for (int i = 0; i < 4 && !test_has_ended; i++) step(0, 0, 0, 0, 1, 0);
        chk("drain_has_ended", test_has_ended, 1);
        chk("drain_ending_low", test_ending, 0);
        for (int i = 0; i < 20; i++) step(1, 2'($urandom_range(0, 3)), i[0], 1, 1, 0);
        chk("ended_no_drop", drop_flag, 0);
        chk("ended_no_pkt", out_valid, 0);
        chk("ended_sticky", test_has_ended, 1);

        // Random traffic with varying consumer throughput.
        for (int r = 0; r < 6; r++) begin
            int rdy_pct;
            rdy_pct = 20 + r * 15;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                step(($urandom % 4) != 0, 2'($urandom_range(0, 3)),
                     ($urandom % 16) == 0, ($urandom % 250) == 0,
                     ($urandom % 100) < rdy_pct, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
